// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between one memory master and data_mem_ctrl.
// Masters hold req until ready; rvalid is a one-cycle completion pulse carrying extended load data.
interface data_mem_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req;
   logic                  ready;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [1:0]            size;
   logic                  is_unsigned;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, we, addr, wdata, size, is_unsigned,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, size, is_unsigned,
      output ready, rvalid, rdata
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Two-master data RAM sequencer with sub-word RMW stores and load extension; rvalid 2 cycles after accept (3 for sub-word stores).
// One op in flight: ready only in IDLE, losers stay pending. Define MEM_CTRL_RR_EN for round-robin ties, else master 0 wins.
module data_mem_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   data_mem_ctrl_if.slave        m0,
   data_mem_ctrl_if.slave        m1,
   output logic                  busy_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

   state_e                state_q, state_d;
   logic                  en_q, en_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;
   logic                  gnt_q, gnt_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;

   logic                  accept;
   logic                  gnt_sel;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [DATA_WIDTH-1:0] resp_dat;

   // en_q keeps ready low while reset is held, without using rst_ni as data
   assign accept = en_q && (state_q == IDLE) && (m0.req || m1.req);

`ifdef MEM_CTRL_RR_EN
   logic last_q, last_d;

   always_comb begin
      gnt_sel = 1'b1;
      if (m0.req) gnt_sel = m1.req ? ~last_q : 1'b0;
      last_d = accept ? gnt_sel : last_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) last_q <= 1'b1;
      else         last_q <= last_d;
   end
`else
   assign gnt_sel = ~m0.req;
`endif

   always_comb begin
      state_d = state_q;
      en_d    = 1'b1;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      gnt_d   = gnt_q;
      buf_d   = buf_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               gnt_d   = gnt_sel;
               we_d    = gnt_sel ? m1.we          : m0.we;
               addr_d  = gnt_sel ? m1.addr        : m0.addr;
               wdata_d = gnt_sel ? m1.wdata       : m0.wdata;
               size_d  = gnt_sel ? m1.size        : m0.size;
               uns_d   = gnt_sel ? m1.is_unsigned : m0.is_unsigned;
               state_d = (we_d && size_d[1]) ? WRITE : READ;
            end
         end
         READ: begin
            buf_d   = mem_rdata_i;
            state_d = we_q ? WRITE : RESP;
         end
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         gnt_q   <= 1'b0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         gnt_q   <= gnt_d;
         buf_q   <= buf_d;
      end
   end

   // Latched fields only move on accept/READ, so these outputs hold through IDLE and RESP
   always_comb begin
      case (size_q)
         2'b00: begin
            mem_wdata_o = {buf_q[DATA_WIDTH-1:8], wdata_q[7:0]};
            load_ext    = {{(DATA_WIDTH-8){~uns_q & buf_q[7]}}, buf_q[7:0]};
         end
         2'b01: begin
            mem_wdata_o = {buf_q[DATA_WIDTH-1:16], wdata_q[15:0]};
            load_ext    = {{(DATA_WIDTH-16){~uns_q & buf_q[15]}}, buf_q[15:0]};
         end
         default: begin
            mem_wdata_o = wdata_q;
            load_ext    = buf_q;
         end
      endcase
      resp_dat = we_q ? '0 : load_ext;
   end

   assign mem_addr_o = addr_q;
   assign mem_we_o   = (state_q == WRITE);
   assign busy_o     = (state_q != IDLE);

   assign m0.ready  = accept && !gnt_sel;
   assign m1.ready  = accept &&  gnt_sel;
   assign m0.rvalid = (state_q == RESP) && !gnt_q;
   assign m1.rvalid = (state_q == RESP) &&  gnt_q;
   assign m0.rdata  = m0.rvalid ? resp_dat : '0;
   assign m1.rdata  = m1.rvalid ? resp_dat : '0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a small word RAM model (combinational read, falling-edge write).
module tb_data_mem_ctrl;
   logic        clk;
   logic        rst_n;
   logic        busy;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] ram [16];

   int total = 0;
   int bad   = 0;

   data_mem_ctrl_if bus0 ();
   data_mem_ctrl_if bus1 ();

   data_mem_ctrl dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .m0          (bus0),
      .m1          (bus1),
      .busy_o      (busy),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = ram[mem_addr[5:2]];
   always @(negedge clk) if (mem_we) ram[mem_addr[5:2]] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit mid, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input bit uns);
      if (!mid) begin
         bus0.req = 1'b1; bus0.we = we; bus0.addr = addr;
         bus0.wdata = wdata; bus0.size = size; bus0.is_unsigned = uns;
      end else begin
         bus1.req = 1'b1; bus1.we = we; bus1.addr = addr;
         bus1.wdata = wdata; bus1.size = size; bus1.is_unsigned = uns;
      end
   endtask

   // One operation: accept, then watch cycles until the granted master's rvalid
   task automatic op(input string tag, input bit mid, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                     input int exp_lat, input logic [31:0] exp_rdata,
                     input int exp_we_cyc, input logic [31:0] exp_wword);
      int n;
      int we_cyc;
      logic [31:0] we_word;
      logic [31:0] rd;
      logic stray;
      @(posedge clk); #1;
      drive(mid, we, addr, wdata, size, uns);
      #1;
      chk({tag, "_ready"}, mid ? bus1.ready : bus0.ready, 1);
      chk({tag, "_other_ready"}, mid ? bus0.ready : bus1.ready, 0);
      @(posedge clk); #1;
      bus0.req = 1'b0;
      bus1.req = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_addr"}, mem_addr, addr);
      n = 1; we_cyc = 0; we_word = 0; stray = 0; rd = 0;
      while (n < 8) begin
         if (mem_we && we_cyc == 0) begin
            we_cyc  = n;
            we_word = mem_wdata;
         end
         if (mid ? bus0.rvalid : bus1.rvalid) stray = 1;
         if (mid ? bus1.rvalid : bus0.rvalid) begin
            rd = mid ? bus1.rdata : bus0.rdata;
            break;
         end
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_rdata"}, rd, exp_rdata);
      chk({tag, "_we_cycle"}, we_cyc, exp_we_cyc);
      if (exp_we_cyc != 0) chk({tag, "_wword"}, we_word, exp_wword);
      chk({tag, "_stray_rvalid"}, stray, 0);
   endtask

   logic [31:0] ext_exp [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_80F0};
   logic [1:0]  ext_size[4] = '{2'b00, 2'b00, 2'b01, 2'b01};
   bit          ext_uns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ng;
      int cyc;
      bit g [4];
      bus0.req = 1'b1; bus0.we = 0; bus0.addr = 0; bus0.wdata = 0; bus0.size = 0; bus0.is_unsigned = 0;
      bus1.req = 1'b0; bus1.we = 0; bus1.addr = 0; bus1.wdata = 0; bus1.size = 0; bus1.is_unsigned = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready0", bus0.ready, 0);
      chk("rst_rvalid0", bus0.rvalid, 0);
      chk("rst_rdata0", bus0.rdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      bus0.req = 1'b0;
      rst_n = 1'b1;

      op("wst",  0, 1, 32'h0001_0000, 32'hDEAD_BEEF, 2'b10, 0, 2, 32'h0, 1, 32'hDEAD_BEEF);
      chk("wst_ram", ram[0], 32'hDEAD_BEEF);
      op("wld",  0, 0, 32'h0001_0000, 32'h0, 2'b10, 0, 2, 32'hDEAD_BEEF, 0, 32'h0);

      op("pre4", 0, 1, 32'h0001_0004, 32'h1122_3344, 2'b10, 0, 2, 32'h0, 1, 32'h1122_3344);
      op("bst",  0, 1, 32'h0001_0004, 32'hFFFF_FFAB, 2'b00, 0, 3, 32'h0, 2, 32'h1122_33AB);
      chk("bst_ram", ram[1], 32'h1122_33AB);

      op("preC", 1, 1, 32'h0001_000C, 32'hCAFE_F00D, 2'b11, 0, 2, 32'h0, 1, 32'hCAFE_F00D);
      op("hst",  1, 1, 32'h0001_000C, 32'h1234_5678, 2'b01, 0, 3, 32'h0, 2, 32'hCAFE_5678);

      op("pre8", 0, 1, 32'h0001_0008, 32'h0000_80F0, 2'b10, 0, 2, 32'h0, 1, 32'h0000_80F0);
      for (int i = 0; i < 4; i++)
         op($sformatf("ext%0d", i), 0, 0, 32'h0001_0008, 32'h0, ext_size[i], ext_uns[i],
            2, ext_exp[i], 0, 32'h0);

      op("m1ld", 1, 0, 32'h0001_0004, 32'h0, 2'b10, 0, 2, 32'h1122_33AB, 0, 32'h0);

      // Both masters request continuously; master 1 was granted last
      @(posedge clk); #1;
      drive(0, 0, 32'h0001_0000, 32'h0, 2'b10, 0);
      drive(1, 0, 32'h0001_0004, 32'h0, 2'b10, 0);
      ng = 0; cyc = 0;
      while (ng < 4 && cyc < 60) begin
         #1;
         if (bus0.ready && bus1.ready) chk("cont_dual_ready", 1, 0);
         if (bus0.ready || bus1.ready) begin
            g[ng] = bus1.ready;
            ng++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus0.req = 1'b0;
      bus1.req = 1'b0;
      chk("cont_grants", ng, 4);
      for (int i = 0; i < 4; i++)
`ifdef MEM_CTRL_RR_EN
         chk($sformatf("cont_grant%0d", i), g[i], i % 2);
`else
         chk($sformatf("cont_grant%0d", i), g[i], 0);
`endif
      cyc = 0;
      while (busy && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("cont_drain", busy, 0);

      // Reset during the WRITE cycle, before the falling edge
      op("pre10", 0, 1, 32'h0001_0010, 32'h5555_5555, 2'b10, 0, 2, 32'h0, 1, 32'h5555_5555);
      @(posedge clk); #1;
      drive(0, 1, 32'h0001_0010, 32'h9999_9999, 2'b10, 0);
      @(posedge clk); #1;
      chk("rmid_we_before", mem_we, 1);
      rst_n = 1'b0;
      #1;
      chk("rmid_we", mem_we, 0);
      chk("rmid_busy", busy, 0);
      chk("rmid_rvalid", bus0.rvalid, 0);
      bus0.req = 1'b0;
      @(negedge clk); #1;
      chk("rmid_ram", ram[4], 32'h5555_5555);
      @(posedge clk); #1;
      chk("rmid_rvalid_late", bus0.rvalid, 0);
      rst_n = 1'b1;
      op("post", 0, 0, 32'h0001_0010, 32'h0, 2'b10, 0, 2, 32'h5555_5555, 0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
